// File: rtl/debug_scratch_word_access.sv
// rtl/debug_scratch_word_access.sv - word-to-byte burst sequencer for the debug RAM scratch port
//
// Accepts one whole-word read or write request at a time from the debug host
// and replays it as NB = 2^WIDTH_LOG single-byte accesses on the RAM scratch
// port. Reads are assembled into a full word; each request gets one response.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid_i / req_ready_o  request handshake (ready only in IDLE)
//   req_write_i                1 = write word, 0 = read word
//   req_index_i                word index
//   req_wdata_i                write word
//   req_bmask_i                per-byte write enable (DEBUG_SCRATCH_BYTE_MASK_EN only)
//   resp_valid_o/resp_ready_i  response handshake
//   resp_rdata_o               assembled read word, 0 for writes
//   busy_o                     byte burst in progress (scratch port owns the RAM)
//   dataScratchAddr_o          {byte_sel, word_index}
//   dataScratchWrData_o        byte to write
//   dataScratchWrEn_o          byte write strobe
//   dataScratchRdData_i        combinational read byte for dataScratchAddr_o
//
// Optional feature macro: DEBUG_SCRATCH_BYTE_MASK_EN

module debug_scratch_word_access #(
    parameter int RAM_LOG   = 8,
    parameter int WIDTH_LOG = 3,
    parameter int DATA_W    = 8 << WIDTH_LOG
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic                         req_write_i,
    input  logic [RAM_LOG-1:0]           req_index_i,
    input  logic [DATA_W-1:0]            req_wdata_i,
`ifdef DEBUG_SCRATCH_BYTE_MASK_EN
    input  logic [(1<<WIDTH_LOG)-1:0]    req_bmask_i,
`endif
    output logic                         resp_valid_o,
    input  logic                         resp_ready_i,
    output logic [DATA_W-1:0]            resp_rdata_o,
    output logic                         busy_o,
    output logic [RAM_LOG+WIDTH_LOG-1:0] dataScratchAddr_o,
    output logic [7:0]                   dataScratchWrData_o,
    output logic                         dataScratchWrEn_o,
    input  logic [7:0]                   dataScratchRdData_i
);

    localparam int NB = 1 << WIDTH_LOG;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RESP
    } state_t;

    state_t                 state;
    state_t                 next_state;

    logic [WIDTH_LOG-1:0]   cnt;
    logic [RAM_LOG-1:0]     idx;
    logic [DATA_W-1:0]      wdata;
    logic [DATA_W-1:0]      acc;
    logic                   is_write;
    logic                   last;
    logic [WIDTH_LOG+2:0]   lane_lsb;
`ifdef DEBUG_SCRATCH_BYTE_MASK_EN
    logic [NB-1:0]          bmask;
`endif

    // Counter saturates at the last lane; the burst never wraps.
    assign last     = (cnt == {WIDTH_LOG{1'b1}});
    assign lane_lsb = {cnt, 3'b000};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state          = state;
        req_ready_o         = 1'b0;
        resp_valid_o        = 1'b0;
        resp_rdata_o        = '0;
        busy_o              = 1'b0;
        dataScratchAddr_o   = '0;
        dataScratchWrData_o = 8'h00;
        dataScratchWrEn_o   = 1'b0;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    next_state = req_write_i ? WRITE : READ;
                end
            end
            WRITE: begin
                busy_o              = 1'b1;
                dataScratchAddr_o   = {cnt, idx};
                dataScratchWrData_o = wdata[lane_lsb +: 8];
`ifdef DEBUG_SCRATCH_BYTE_MASK_EN
                // Masked lanes still spend their cycle so latency is fixed.
                dataScratchWrEn_o   = bmask[cnt];
`else
                dataScratchWrEn_o   = 1'b1;
`endif
                if (last) begin
                    next_state = RESP;
                end
            end
            READ: begin
                busy_o            = 1'b1;
                dataScratchAddr_o = {cnt, idx};
                if (last) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                resp_valid_o = 1'b1;
                resp_rdata_o = is_write ? '0 : acc;
                // Returning to IDLE first keeps a new request out of this cycle.
                if (resp_ready_i) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            idx      <= '0;
            wdata    <= '0;
            acc      <= '0;
            is_write <= 1'b0;
`ifdef DEBUG_SCRATCH_BYTE_MASK_EN
            bmask    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        cnt      <= '0;
                        acc      <= '0;
                        idx      <= req_index_i;
                        wdata    <= req_wdata_i;
                        is_write <= req_write_i;
`ifdef DEBUG_SCRATCH_BYTE_MASK_EN
                        bmask    <= req_bmask_i;
`endif
                    end
                end
                WRITE: begin
                    if (!last) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READ: begin
                    // Read byte is combinational from the RAM for the current address.
                    acc[lane_lsb +: 8] <= dataScratchRdData_i;
                    if (!last) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_scratch_word_access.sv
// tb/tb_debug_scratch_word_access.sv - scoreboard bench for debug_scratch_word_access
module tb_debug_scratch_word_access;

    localparam int NB = 8;

    typedef struct packed {
        logic        busy;
        logic        en;
        logic [10:0] addr;
        logic [7:0]  wd;
    } op_t;

    typedef struct packed {
        logic        valid;
        logic        busy;
        logic        ready;
        logic [63:0] rdata;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [7:0]  req_index_i;
    logic [63:0] req_wdata_i;
`ifdef DEBUG_SCRATCH_BYTE_MASK_EN
    logic [7:0]  req_bmask_i;
`endif
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [63:0] resp_rdata_o;
    logic        busy_o;
    logic [10:0] dataScratchAddr_o;
    logic [7:0]  dataScratchWrData_o;
    logic        dataScratchWrEn_o;
    logic [7:0]  dataScratchRdData_i;

    logic [7:0]  ram [0:2047];

    op_t   exp_op_q[$];
    op_t   obs_op_q[$];
    resp_t exp_resp_q[$];
    resp_t obs_resp_q[$];

    int tests_run    = 0;
    int tests_failed = 0;

    debug_scratch_word_access dut (
        .clk                 (clk),
        .reset               (reset),
        .req_valid_i         (req_valid_i),
        .req_ready_o         (req_ready_o),
        .req_write_i         (req_write_i),
        .req_index_i         (req_index_i),
        .req_wdata_i         (req_wdata_i),
`ifdef DEBUG_SCRATCH_BYTE_MASK_EN
        .req_bmask_i         (req_bmask_i),
`endif
        .resp_valid_o        (resp_valid_o),
        .resp_ready_i        (resp_ready_i),
        .resp_rdata_o        (resp_rdata_o),
        .busy_o              (busy_o),
        .dataScratchAddr_o   (dataScratchAddr_o),
        .dataScratchWrData_o (dataScratchWrData_o),
        .dataScratchWrEn_o   (dataScratchWrEn_o),
        .dataScratchRdData_i (dataScratchRdData_i)
    );

    always #5 clk = ~clk;

    // Byte-wide RAM model behind the scratch port.
    assign dataScratchRdData_i = ram[dataScratchAddr_o];
    always @(posedge clk) begin
        if (dataScratchWrEn_o) ram[dataScratchAddr_o] <= dataScratchWrData_o;
    end

    // Drives one request, pushes expected byte ops and response, and records
    // what the DUT shows in cycles 1..NB and NB+1.
    task automatic run_txn(input logic wr, input logic [7:0] idx, input logic [63:0] wd,
                           input logic [7:0] mask, input logic [63:0] exp_rd);
        op_t   e;
        op_t   o;
        resp_t r;
        @(posedge clk); #1;
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_index_i = idx;
        req_wdata_i = wd;
`ifdef DEBUG_SCRATCH_BYTE_MASK_EN
        req_bmask_i = mask;
`endif
        for (int b = 0; b < NB; b++) begin
            e.busy = 1'b1;
            e.en   = wr & mask[b];
            e.addr = {3'(b), idx};
            e.wd   = wr ? wd[8*b +: 8] : 8'h00;
            exp_op_q.push_back(e);
        end
        r.valid = 1'b1;
        r.busy  = 1'b0;
        r.ready = 1'b0;
        r.rdata = wr ? 64'h0 : exp_rd;
        exp_resp_q.push_back(r);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        for (int b = 0; b < NB; b++) begin
            @(negedge clk);
            o.busy = busy_o;
            o.en   = dataScratchWrEn_o;
            o.addr = dataScratchAddr_o;
            o.wd   = dataScratchWrData_o;
            obs_op_q.push_back(o);
        end
        @(negedge clk);
        r.valid = resp_valid_o;
        r.busy  = busy_o;
        r.ready = req_ready_o;
        r.rdata = resp_rdata_o;
        obs_resp_q.push_back(r);
    endtask

    task automatic test_reset;
        reset        = 1'b1;
        req_valid_i  = 1'b0;
        req_write_i  = 1'b0;
        req_index_i  = 8'h00;
        req_wdata_i  = 64'h0;
`ifdef DEBUG_SCRATCH_BYTE_MASK_EN
        req_bmask_i  = 8'hFF;
`endif
        resp_ready_i = 1'b1;
        for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
        #2;
        tests_run++;
        if ({busy_o, resp_valid_o, dataScratchWrEn_o, dataScratchAddr_o, dataScratchWrData_o, resp_rdata_o} !== '0
            || req_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_outputs got busy=%b rv=%b we=%b addr=%h wd=%h rd=%h rdy=%b expected all 0, rdy=1",
                     busy_o, resp_valid_o, dataScratchWrEn_o, dataScratchAddr_o, dataScratchWrData_o,
                     resp_rdata_o, req_ready_o);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_write;
        op_t e, o;
        resp_t re, ro;
        run_txn(1'b1, 8'h05, 64'h8877665544332211, 8'hFF, 64'h0);
        for (int b = 0; b < NB; b++) begin
            e = exp_op_q.pop_front();
            o = obs_op_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL write_op[%0d] got %h expected %h", b, o, e);
            end
        end
        re = exp_resp_q.pop_front();
        ro = obs_resp_q.pop_front();
        tests_run++;
        if (ro !== re) begin
            tests_failed++;
            $display("FAIL write_resp got %h expected %h", ro, re);
        end
    endtask

    task automatic test_read;
        op_t e, o;
        resp_t re, ro;
        run_txn(1'b0, 8'h05, 64'h0, 8'hFF, 64'h8877665544332211);
        for (int b = 0; b < NB; b++) begin
            e = exp_op_q.pop_front();
            o = obs_op_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL read_op[%0d] got %h expected %h", b, o, e);
            end
        end
        re = exp_resp_q.pop_front();
        ro = obs_resp_q.pop_front();
        tests_run++;
        if (ro !== re) begin
            tests_failed++;
            $display("FAIL read_resp got %h expected %h", ro, re);
        end
    endtask

    task automatic test_resp_hold;
        resp_t re, ro;
        resp_ready_i = 1'b0;
        run_txn(1'b0, 8'h05, 64'h0, 8'hFF, 64'h8877665544332211);
        exp_op_q.delete();
        obs_op_q.delete();
        re = exp_resp_q.pop_front();
        ro = obs_resp_q.pop_front();
        tests_run++;
        if (ro !== re) begin
            tests_failed++;
            $display("FAIL hold_first_resp got %h expected %h", ro, re);
        end
        // A new request waits while the response is stalled.
        req_valid_i = 1'b1;
        req_write_i = 1'b1;
        req_index_i = 8'h33;
        req_wdata_i = 64'h0123456789ABCDEF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            ro.valid = resp_valid_o;
            ro.busy  = busy_o;
            ro.ready = req_ready_o;
            ro.rdata = resp_rdata_o;
            tests_run++;
            if (ro !== re) begin
                tests_failed++;
                $display("FAIL hold_stable[%0d] got %h expected %h", k, ro, re);
            end
        end
        resp_ready_i = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({resp_valid_o, req_ready_o, busy_o} !== 3'b010) begin
            tests_failed++;
            $display("FAIL hold_after_handshake got rv,rdy,busy=%b expected 010",
                     {resp_valid_o, req_ready_o, busy_o});
        end
        @(negedge clk);
        req_valid_i = 1'b0;
        tests_run++;
        if ({busy_o, dataScratchAddr_o} !== {1'b1, 11'h033}) begin
            tests_failed++;
            $display("FAIL hold_next_accept got busy,addr=%h expected %h",
                     {busy_o, dataScratchAddr_o}, {1'b1, 11'h033});
        end
        repeat (NB) @(negedge clk);
        tests_run++;
        if ({resp_valid_o, resp_rdata_o} !== {1'b1, 64'h0}) begin
            tests_failed++;
            $display("FAIL hold_next_resp got %h expected %h", {resp_valid_o, resp_rdata_o}, {1'b1, 64'h0});
        end
    endtask

    task automatic test_reset_mid_burst;
        logic [63:0] wd;
        logic [7:0]  exp_b;
        int          seen_resp;
        wd = 64'hAABBCCDDEEFF0011;
        for (int b = 0; b < NB; b++) ram[{3'(b), 8'h10}] = 8'h5A;
        @(posedge clk); #1;
        req_valid_i = 1'b1;
        req_write_i = 1'b1;
        req_index_i = 8'h10;
        req_wdata_i = wd;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        tests_run++;
        if ({busy_o, resp_valid_o, dataScratchWrEn_o, dataScratchAddr_o, dataScratchWrData_o, resp_rdata_o} !== '0) begin
            tests_failed++;
            $display("FAIL midreset_outputs got busy=%b rv=%b we=%b addr=%h wd=%h expected all 0",
                     busy_o, resp_valid_o, dataScratchWrEn_o, dataScratchAddr_o, dataScratchWrData_o);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        seen_resp = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (resp_valid_o === 1'b1 || busy_o === 1'b1) seen_resp++;
        end
        tests_run++;
        if (seen_resp !== 0) begin
            tests_failed++;
            $display("FAIL midreset_no_resp got %0d active cycles expected 0", seen_resp);
        end
        for (int b = 0; b < NB; b++) begin
            exp_b = (b < 3) ? wd[8*b +: 8] : 8'h5A;
            tests_run++;
            if (ram[{3'(b), 8'h10}] !== exp_b) begin
                tests_failed++;
                $display("FAIL midreset_ram[%0d] got %h expected %h", b, ram[{3'(b), 8'h10}], exp_b);
            end
        end
    endtask

    task automatic test_back_to_back;
        op_t e, o;
        resp_t re, ro;
        resp_ready_i = 1'b1;
        run_txn(1'b1, 8'hFF, 64'hF0E1D2C3B4A59687, 8'hFF, 64'h0);
        run_txn(1'b1, 8'h00, 64'h1122334455667788, 8'hFF, 64'h0);
        for (int b = 0; b < 2*NB; b++) begin
            e = exp_op_q.pop_front();
            o = obs_op_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL b2b_op[%0d] got %h expected %h", b, o, e);
            end
        end
        for (int t = 0; t < 2; t++) begin
            re = exp_resp_q.pop_front();
            ro = obs_resp_q.pop_front();
            tests_run++;
            if (ro !== re) begin
                tests_failed++;
                $display("FAIL b2b_resp[%0d] got %h expected %h", t, ro, re);
            end
        end
    endtask

`ifdef DEBUG_SCRATCH_BYTE_MASK_EN
    task automatic test_bmask;
        op_t e, o;
        resp_t re, ro;
        run_txn(1'b1, 8'h40, 64'hCAFEBABEDEADBEEF, 8'b1010_0101, 64'h0);
        for (int b = 0; b < NB; b++) begin
            e = exp_op_q.pop_front();
            o = obs_op_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL bmask_op[%0d] got %h expected %h", b, o, e);
            end
        end
        re = exp_resp_q.pop_front();
        ro = obs_resp_q.pop_front();
        tests_run++;
        if (ro !== re) begin
            tests_failed++;
            $display("FAIL bmask_resp got %h expected %h", ro, re);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_resp_hold();
        test_reset_mid_burst();
        test_back_to_back();
`ifdef DEBUG_SCRATCH_BYTE_MASK_EN
        test_bmask();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/debug_scratch_word_access.md
Name: debug_scratch_word_access

Overview:
- Upstream sequencer for the debug data RAM's byte-wide scratch port.
- Accepts whole-word read/write requests from the debug host interface and turns each one into a burst of single-byte accesses on the scratch address, write-data and write-enable lines.
- Assembles read bytes into a full word and returns one response per request.
- Drives busy_o so core-side logic knows its own RAM writes are being overridden, since scratch writes take priority in the RAM.

Parameters:
- RAM_LOG, 8, log2 of RAM depth; width of the word index.
- WIDTH_LOG, 3, log2 of bytes per word; NB = 2^WIDTH_LOG bytes.
- DATA_W, 8<<WIDTH_LOG, word width in bits (derived; do not override).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  host request valid.
- req_ready_o  out  1  block can accept a request.
- req_write_i  in  1  1 = write word, 0 = read word.
- req_index_i  in  RAM_LOG  word index.
- req_wdata_i  in  DATA_W  write data.
- resp_valid_o  out  1  response available.
- resp_ready_i  in  1  host accepts response.
- resp_rdata_o  out  DATA_W  assembled read word; 0 for writes.
- busy_o  out  1  byte burst in progress.
- dataScratchAddr_o  out  RAM_LOG+WIDTH_LOG  {byte_sel, word_index}; byte_sel occupies the upper WIDTH_LOG bits.
- dataScratchWrData_o  out  8  byte to write.
- dataScratchWrEn_o  out  1  byte write strobe.
- dataScratchRdData_i  in  8  combinational read byte for the current dataScratchAddr_o.

Behaviour:
- States: IDLE, WRITE, READ, RESP.
- Reset (asynchronous, any state, mid-burst included):
  - state=IDLE; byte counter, latched index, latched write data and read accumulator cleared.
  - Outputs: req_ready_o=1 once state is IDLE; resp_valid_o=0, resp_rdata_o=0, busy_o=0, dataScratchAddr_o=0, dataScratchWrData_o=0, dataScratchWrEn_o=0.
  - An aborted burst leaves partially written bytes in the RAM; no response is generated.
- Request acceptance:
  - req_ready_o=1 only in IDLE.
  - Handshake (req_valid_i & req_ready_o) latches index, write flag and data, clears counter b=0 and the accumulator, and moves to WRITE or READ.
- WRITE, one cycle per byte, b = 0..NB-1:
  - dataScratchAddr_o = {b, index}.
  - dataScratchWrData_o = wdata[8b+7:8b].
  - dataScratchWrEn_o = 1.
- READ, one cycle per byte:
  - dataScratchAddr_o = {b, index}, dataScratchWrEn_o = 0.
  - At the clock edge, dataScratchRdData_i is captured into accumulator lane b.
- Burst end: at b = NB-1, counter stops and state moves to RESP; no wrap.
- busy_o = 1 in WRITE or READ.
- In IDLE and RESP, scratch address, write data and write enable are driven to 0.
- RESP:
  - resp_valid_o = 1; resp_rdata_o = accumulator for reads, 0 for writes.
  - Held stable until resp_ready_i.
  - Handshake returns to IDLE; no request is accepted in the same cycle (req_ready_o=0 in RESP).
- Latency: request accepted on edge 0; byte ops in cycles 1..NB; resp_valid_o first high in cycle NB+1. Write and read both take NB+1 cycles to response.
- Only one request outstanding at a time.
- req_* inputs are ignored outside IDLE.

Optional Feature:
DEBUG_SCRATCH_BYTE_MASK_EN
- Defined:
  - Adds input req_bmask_i [NB-1:0], latched at acceptance.
  - In WRITE, dataScratchWrEn_o = bmask[b]. Masked lanes still consume their cycle, so latency is unchanged.
  - Mask is ignored for reads.
- Undefined: port absent; every lane is written.

Test Plan:
- Reset, then write index 0x05 with data 0x8877665544332211 (NB=8) -> 8 consecutive cycles with WrEn=1, addr 0x005,0x105,...,0x705 and WrData 0x11..0x88; resp_valid_o in cycle 9 with resp_rdata_o=0.
- Read index 0x05 with a RAM model returning the previously written bytes -> resp_rdata_o=0x8877665544332211, busy_o high for exactly 8 cycles.
- Hold resp_ready_i=0 for 5 cycles after a read -> resp_valid_o and resp_rdata_o stay stable; req_ready_o stays 0; a new req_valid_i is not accepted until the cycle after the response handshake.
- Assert reset in the 4th cycle of a write burst -> all outputs 0 immediately (asynchronous); after release only bytes 0..2 are modified in the RAM model; no response is produced.
- Back-to-back writes to indices 0xFF then 0x00 with resp_ready_i tied 1 -> correct address wrap of the index field; no WrEn gap other than the IDLE/RESP cycles.
- With DEBUG_SCRATCH_BYTE_MASK_EN and req_bmask_i=8'b1010_0101 -> WrEn high only for b=0,2,5,7; response still in cycle 9.
